copper_sync_seq: RTL

Sequencer for the copper multi-FPGA clock-count link. It drives the `sync` transmitter's enable/reset, collects 2^NAVGLOG round-trip samples from the returned clock counts, and publishes the averaged round-trip and one-way delay for software to turn into the clock-count correction. It also arms a one-shot trigger that fires when the DSP clock count reaches a programmed value. It sits in the dspclk domain between `dspregs` and the `sync` instance.

---
 rtl/copper_sync_pkg.sv | 16 +
 rtl/copper_sync_seq_trig.sv | 35 +++
 rtl/copper_sync_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/copper_sync_pkg.sv
// Shared types and default widths for the copper link sync sequencer.
package copper_sync_pkg;

    localparam int CNTWIDTH_DEF = 64;
    localparam int TOWIDTH_DEF  = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACC,
        S_GAP,
        S_DONE
    } state_t;

endpackage

// File: rtl/copper_sync_seq_trig.sv
// One-shot scheduled strobe: fires once when the clock count reaches a compare value.
import copper_sync_pkg::*;

module copper_trig #(
    parameter int CNTWIDTH = CNTWIDTH_DEF
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [CNTWIDTH-1:0] clkcnt,
    input  logic [CNTWIDTH-1:0] trig_cnt,
    input  logic                arm,
    output logic                fire
);

    logic armed;
    logic hit;

    assign hit = armed && (clkcnt >= trig_cnt);

    // A fresh arm takes priority over the clear caused by a hit on the same cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            armed <= 1'b0;
            fire  <= 1'b0;
        end else begin
            fire <= hit;
            if (arm) begin
                armed <= 1'b1;
            end else if (hit) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/copper_sync_seq.sv
// Round-trip measurement sequencer for the copper clock-count link, plus a
// one-shot clock-count trigger.
import copper_sync_pkg::*;

module copper_sync_seq #(
    parameter int CNTWIDTH = CNTWIDTH_DEF,
    parameter int NAVGLOG  = 3,
    parameter int RSTLEN   = 4,
    parameter int TOWIDTH  = TOWIDTH_DEF,
    parameter int GAP      = 16
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                start,
    output logic                tx_en,
    output logic                tx_rst,
    input  logic [CNTWIDTH-1:0] tx_clkcnt,
    input  logic [CNTWIDTH-1:0] rx_clkcnt,
    input  logic                rx_stb,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [TOWIDTH-1:0]  rtt_avg,
    output logic [TOWIDTH-1:0]  oneway,
    input  logic [CNTWIDTH-1:0] clkcnt,
    input  logic [CNTWIDTH-1:0] trig_cnt,
    input  logic                arm,
    output logic                fire
);

    localparam int ACCW = TOWIDTH + NAVGLOG;
    localparam logic [TOWIDTH-1:0] LAUNCH_LAST = TOWIDTH'(RSTLEN - 1);
    localparam logic [TOWIDTH-1:0] GAP_LAST    = TOWIDTH'(GAP - 1);
    // Last WAIT cycle: the counter would reach 2^TOWIDTH-1 on the next edge.
    localparam logic [TOWIDTH-1:0] TO_LAST     = TOWIDTH'((64'd1 << TOWIDTH) - 64'd2);
    localparam logic [NAVGLOG:0]   SAMP_LAST   = (NAVGLOG + 1)'((1 << NAVGLOG) - 1);

    state_t                state;
    state_t                state_next;
    logic [TOWIDTH-1:0]    cnt;
    logic [CNTWIDTH-1:0]   diff_p1;
    logic [ACCW-1:0]       acc;
    logic [ACCW-1:0]       acc_sum;
    logic [NAVGLOG:0]      nsamp;
    logic                  err_r;
    logic                  launch_end;
    logic                  gap_end;
    logic                  wait_to;
    logic                  diff_bad;
    logic                  last_samp;

    function automatic logic [TOWIDTH-1:0] avg_floor(input logic [ACCW-1:0] a);
        return a[ACCW-1:NAVGLOG];
    endfunction

    function automatic logic [TOWIDTH-1:0] half_floor(input logic [TOWIDTH-1:0] v);
        return v >> 1;
    endfunction

    assign launch_end = (cnt == LAUNCH_LAST);
    assign gap_end    = (cnt == GAP_LAST);
    assign wait_to    = (cnt == TO_LAST);
    // Any bit above the valid RTT range also catches wrapped (negative) differences.
    assign diff_bad   = |diff_p1[CNTWIDTH-1:TOWIDTH];
    assign last_samp  = (nsamp == SAMP_LAST);
    assign acc_sum    = acc + {{NAVGLOG{1'b0}}, diff_p1[TOWIDTH-1:0]};
    assign err        = err_r;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_en      = 1'b0;
        tx_rst     = 1'b0;
        done       = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                tx_en  = 1'b1;
                tx_rst = 1'b1;
                if (launch_end) state_next = S_WAIT;
            end
            S_WAIT: begin
                tx_en = 1'b1;
                if (rx_stb) begin
                    state_next = S_ACC;
                end else if (wait_to) begin
                    state_next = S_IDLE;
                end
            end
            S_ACC: begin
                if (diff_bad) begin
                    state_next = S_IDLE;
                end else if (last_samp) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) state_next = S_LAUNCH;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Stage p1: difference captured in WAIT; accumulated in ACC on the next cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt     <= '0;
            diff_p1 <= '0;
            acc     <= '0;
            nsamp   <= '0;
            err_r   <= 1'b0;
            rtt_avg <= '0;
            oneway  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        acc   <= '0;
                        nsamp <= '0;
                        err_r <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    cnt <= launch_end ? '0 : cnt + 1'b1;
                end
                S_WAIT: begin
                    if (rx_stb) begin
                        diff_p1 <= rx_clkcnt - tx_clkcnt;
                    end else if (wait_to) begin
                        err_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACC: begin
                    if (diff_bad) begin
                        err_r <= 1'b1;
                    end else begin
                        acc   <= acc_sum;
                        nsamp <= nsamp + 1'b1;
                        cnt   <= '0;
                        if (last_samp) begin
                            rtt_avg <= avg_floor(acc_sum);
                            oneway  <= half_floor(avg_floor(acc_sum));
                        end
                    end
                end
                S_GAP: begin
                    cnt <= gap_end ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    copper_trig #(
        .CNTWIDTH (CNTWIDTH)
    ) u_trig (
        .clk      (clk),
        .aresetn  (aresetn),
        .clkcnt   (clkcnt),
        .trig_cnt (trig_cnt),
        .arm      (arm),
        .fire     (fire)
    );

endmodule
